// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file micro-op sequencer.
package regfile_seq_pkg;

    // Command op codes as presented on cmd_op
    typedef enum logic [1:0] {
        OP_MOVE  = 2'b00,
        OP_SWAP  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_INC   = 2'b11
    } op_e;

    // Sequencer states; ST2/ST3 are only visited by SWAP
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ST1  = 2'b01,
        ST2  = 2'b10,
        ST3  = 2'b11
    } state_e;

    // Register file FunSel codes
    localparam logic [2:0] FUN_DEC  = 3'b000;
    localparam logic [2:0] FUN_INC  = 3'b001;
    localparam logic [2:0] FUN_LOAD = 3'b010;
    localparam logic [2:0] FUN_CLR  = 3'b011;

    // Register indices: 0-3 general purpose, 4-7 scratch
    localparam logic [2:0] R1 = 3'd0;
    localparam logic [2:0] R2 = 3'd1;
    localparam logic [2:0] R3 = 3'd2;
    localparam logic [2:0] R4 = 3'd3;
    localparam logic [2:0] S1 = 3'd4;
    localparam logic [2:0] S2 = 3'd5;
    localparam logic [2:0] S3 = 3'd6;
    localparam logic [2:0] S4 = 3'd7;

    // S4 is the SWAP temporary, so a SWAP touching it would corrupt itself
    localparam logic [2:0] TMP_IDX = S4;

    function automatic logic swap_rejected(input op_e op, input logic [2:0] a,
                                           input logic [2:0] b);
        return (op == OP_SWAP) && ((a == TMP_IDX) || (b == TMP_IDX));
    endfunction

endpackage

// File: rtl/rf_sel_decode.sv
// Index-to-enable decoder: drives exactly one active-low RegSel/ScrSel bit when writing.
module rf_sel_decode (
    input  logic [2:0] i_idx,
    input  logic       i_we,
    output logic [3:0] o_reg_sel,
    output logic [3:0] o_scr_sel
);

    logic [1:0] w_bit;

    // Bit 3 maps to the lowest index (R1/S1), bit 0 to the highest (R4/S4)
    assign w_bit = 2'd3 - i_idx[1:0];

    // Decode write target into the two active-low enable groups
    always_comb begin
        o_reg_sel = 4'b1111;
        o_scr_sel = 4'b1111;
        if (i_we) begin
            if (i_idx[2]) begin
                o_scr_sel[w_bit] = 1'b0;
            end else begin
                o_reg_sel[w_bit] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Multi-cycle MOVE/SWAP/CLEAR/INC sequencer driving the 4 GPR + 4 scratch register file.
module regfile_op_sequencer
    import regfile_seq_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_a,
    input  logic [2:0]  cmd_b,
    output logic        done,
    output logic        err,
    input  logic [15:0] rf_outa,
    output logic [15:0] RF_I,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel
);

    state_e     r_state;
    op_e        r_op;
    logic [2:0] r_a;
    logic [2:0] r_b;
    logic [2:0] r_outasel;
    logic [2:0] r_funsel;
    logic [2:0] r_wr_idx;
    logic       r_wr_en;
    logic       r_done;
    logic       r_err;

    op_e        w_op;

    assign w_op = op_e'(cmd_op);

    // FSM with registered control outputs: each edge loads the controls for the next cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_op      <= OP_MOVE;
            r_a       <= 3'd0;
            r_b       <= 3'd0;
            r_outasel <= 3'd0;
            r_funsel  <= FUN_LOAD;
            r_wr_idx  <= 3'd0;
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // Idle defaults unless a write state is being entered
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_outasel <= 3'd0;
            r_funsel  <= FUN_LOAD;
            r_wr_idx  <= 3'd0;
            r_wr_en   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (swap_rejected(w_op, cmd_a, cmd_b)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_op    <= w_op;
                            r_a     <= cmd_a;
                            r_b     <= cmd_b;
                            r_state <= ST1;
                            r_wr_en <= 1'b1;
                            unique case (w_op)
                                OP_MOVE: begin
                                    r_outasel <= cmd_a;
                                    r_wr_idx  <= cmd_b;
                                end
                                OP_SWAP: begin
                                    r_outasel <= cmd_a;
                                    r_wr_idx  <= TMP_IDX;
                                end
                                OP_CLEAR: begin
                                    r_funsel <= FUN_CLR;
                                    r_wr_idx <= cmd_a;
                                end
                                OP_INC: begin
                                    r_funsel <= FUN_INC;
                                    r_wr_idx <= cmd_a;
                                end
                            endcase
                        end
                    end
                end
                ST1: begin
                    if (r_op == OP_SWAP) begin
                        r_state   <= ST2;
                        r_outasel <= r_b;
                        r_wr_idx  <= r_a;
                        r_wr_en   <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                ST2: begin
                    r_state   <= ST3;
                    r_outasel <= TMP_IDX;
                    r_wr_idx  <= r_b;
                    r_wr_en   <= 1'b1;
                end
                ST3: begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

    rf_sel_decode u_sel_decode (
        .i_idx     (r_wr_idx),
        .i_we      (r_wr_en),
        .o_reg_sel (RF_RegSel),
        .o_scr_sel (RF_ScrSel)
    );

    assign cmd_ready  = (r_state == IDLE);
    assign done       = r_done;
    assign err        = r_err;
    assign RF_I       = rf_outa;
    assign RF_OutASel = r_outasel;
    assign RF_OutBSel = 3'd0;
    assign RF_FunSel  = r_funsel;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench: sequencer driving a behavioural register file, scoreboard of expected completions.
module tb_regfile_op_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [2:0]  cmd_a = 3'd0;
    logic [2:0]  cmd_b = 3'd0;
    logic        done;
    logic        err;
    logic [15:0] rf_outa;
    logic [15:0] RF_I;
    logic [2:0]  RF_OutASel;
    logic [2:0]  RF_OutBSel;
    logic [2:0]  RF_FunSel;
    logic [3:0]  RF_RegSel;
    logic [3:0]  RF_ScrSel;

    regfile_op_sequencer dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .done       (done),
        .err        (err),
        .rf_outa    (rf_outa),
        .RF_I       (RF_I),
        .RF_OutASel (RF_OutASel),
        .RF_OutBSel (RF_OutBSel),
        .RF_FunSel  (RF_FunSel),
        .RF_RegSel  (RF_RegSel),
        .RF_ScrSel  (RF_ScrSel)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Behavioural register file: index 0-3 = R1-R4, 4-7 = S1-S4
    logic [15:0] rf [8];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_idx = 3'd0;
    logic [15:0] pl_val = 16'h0;

    assign rf_outa = rf[RF_OutASel];

    function automatic logic rf_we(input int i);
        if (i < 4) return !RF_RegSel[3 - i];
        return !RF_ScrSel[7 - i];
    endfunction

    always @(posedge Clock) begin
        if (pl_en) begin
            rf[pl_idx] <= pl_val;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (rf_we(i)) begin
                    case (RF_FunSel)
                        3'b000:  rf[i] <= rf[i] - 16'd1;
                        3'b001:  rf[i] <= rf[i] + 16'd1;
                        3'b010:  rf[i] <= RF_I;
                        3'b011:  rf[i] <= 16'h0;
                        default: ;
                    endcase
                end
            end
        end
    end

    typedef struct {
        string       tag;
        bit          is_err;
        int          lat;
        int          n;
        logic [2:0]  idx0;
        logic [15:0] val0;
        logic [2:0]  idx1;
        logic [15:0] val1;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any completion pulse seen there
    task automatic step();
        exp_t e;
        @(negedge Clock);
        if (done || err) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_pulse: observed done=%0b err=%0b expected none", done, err);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_kind"}, {30'd0, done, err}, e.is_err ? 32'd1 : 32'd2);
                // Latency counted in rising edges from the accept edge to the edge sampling the pulse
                check({e.tag, "_lat"}, cyc + 1 - acc_cyc, e.lat);
                if (!e.is_err) begin
                    if (e.n > 0) check({e.tag, "_val0"}, rf[e.idx0], e.val0);
                    if (e.n > 1) check({e.tag, "_val1"}, rf[e.idx1], e.val1);
                end
            end
        end
    endtask

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        step();
        pl_en  = 1'b0;
    endtask

    // Hold the command until ready, push its expectation, then release after the accept edge
    task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                        input exp_t e);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        for (int k = 0; k < 20 && !cmd_ready; k++) step();
        if (!cmd_ready) begin
            checks++;
            errors++;
            $error("FAIL %s_accept_timeout: observed ready=0 expected ready=1", e.tag);
        end
        acc_cyc = cyc + 1;
        sb.push_back(e);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL %s_done_timeout: observed pending=%0d expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    function automatic exp_t mk(input string tag, input bit is_err, input int lat, input int n,
                                input logic [2:0] i0, input logic [15:0] v0,
                                input logic [2:0] i1, input logic [15:0] v1);
        exp_t e;
        e.tag = tag; e.is_err = is_err; e.lat = lat; e.n = n;
        e.idx0 = i0; e.val0 = v0; e.idx1 = i1; e.val1 = v1;
        return e;
    endfunction

    initial begin
        // Reset state
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        check("rst_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_sel", {RF_RegSel, RF_ScrSel}, 8'hFF);
        check("rst_outa", RF_OutASel, 0);
        check("rst_outb", RF_OutBSel, 0);
        check("rst_fun", RF_FunSel, 3'b010);

        // MOVE R1 -> R3
        preload(3'd0, 16'h1234);
        send(2'b00, 3'd0, 3'd2, mk("move", 0, 2, 1, 3'd2, 16'h1234, 3'd0, 16'h1234));
        check("move_regsel", RF_RegSel, 4'b1101);
        check("move_scrsel", RF_ScrSel, 4'b1111);
        check("move_outa", RF_OutASel, 0);
        check("move_fun", RF_FunSel, 3'b010);
        check("move_rfi", RF_I, 16'h1234);
        drain("move");

        // SWAP R2 <-> R4 through S4
        preload(3'd1, 16'hAAAA);
        preload(3'd3, 16'h5555);
        send(2'b01, 3'd1, 3'd3, mk("swap", 0, 4, 2, 3'd1, 16'h5555, 3'd3, 16'hAAAA));
        check("swap_st1_sel", {RF_RegSel, RF_ScrSel}, 8'hFE);
        check("swap_st1_outa", RF_OutASel, 1);
        check("swap_st1_ready", cmd_ready, 0);
        step();
        check("swap_st2_sel", {RF_RegSel, RF_ScrSel}, 8'hBF);
        check("swap_st2_outa", RF_OutASel, 3);
        step();
        check("swap_st3_sel", {RF_RegSel, RF_ScrSel}, 8'hEF);
        check("swap_st3_outa", RF_OutASel, 7);
        drain("swap");
        check("swap_tmp", rf[7], 16'hAAAA);

        // SWAP touching the temporary is rejected
        send(2'b01, 3'd7, 3'd0, mk("reject", 1, 1, 0, 3'd0, 16'h0, 3'd0, 16'h0));
        for (int k = 0; k < 3; k++) begin
            check("reject_sel", {RF_RegSel, RF_ScrSel}, 8'hFF);
            check("reject_ready", cmd_ready, 1);
            step();
        end
        check("reject_r1", rf[0], 16'h1234);

        // INC wraps, then CLEAR issued in the INC done cycle
        preload(3'd3, 16'hFFFF);
        preload(3'd4, 16'h7777);
        send(2'b11, 3'd3, 3'd0, mk("inc", 0, 2, 1, 3'd3, 16'h0000, 3'd0, 16'h0));
        check("inc_fun", RF_FunSel, 3'b001);
        drain("inc");
        check("inc_done_ready", cmd_ready, 1);
        send(2'b10, 3'd4, 3'd0, mk("clear", 0, 2, 1, 3'd4, 16'h0000, 3'd0, 16'h0));
        check("clear_fun", RF_FunSel, 3'b011);
        check("clear_sel", {RF_RegSel, RF_ScrSel}, 8'hF7);
        drain("clear");

        // Reset during ST2 of a SWAP abandons it
        send(2'b01, 3'd0, 3'd1, mk("swap_rst", 0, 4, 0, 3'd0, 16'h0, 3'd0, 16'h0));
        step();
        Reset = 1'b1;
        sb.delete();
        step();
        Reset = 1'b0;
        check("rstmid_sel", {RF_RegSel, RF_ScrSel}, 8'hFF);
        check("rstmid_ready", cmd_ready, 1);
        check("rstmid_done", done, 0);
        check("rstmid_tmp", rf[7], 16'h1234);
        for (int k = 0; k < 5; k++) step();

        // MOVE held during a SWAP runs once, after the SWAP
        preload(3'd5, 16'h2222);
        preload(3'd6, 16'h3333);
        send(2'b01, 3'd5, 3'd6, mk("swap2", 0, 4, 2, 3'd5, 16'h3333, 3'd6, 16'h2222));
        send(2'b00, 3'd5, 3'd0, mk("held_move", 0, 2, 1, 3'd0, 16'h3333, 3'd5, 16'h3333));
        check("held_move_sel", RF_RegSel, 4'b0111);
        drain("held_move");
        for (int k = 0; k < 5; k++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
